// File: rtl/jump_branch_resolve_if.sv
// Interface bundling the ID/EX operand bus and the redirect/flush/link
// outputs of the jump/branch resolver. The master side is the pipeline
// that feeds operands and consumes redirects; the slave side is the resolver.
interface jump_branch_resolve_if #(
   parameter int CNT_W = 32
);
   logic             stall;
   logic             valid_in;
   logic [2:0]       jump_branch;
   logic [31:0]      pc_plus4;
   logic [31:0]      rs_data;
   logic [31:0]      rt_data;
   logic [15:0]      offset;
   logic [25:0]      target;

   logic             redirect;
   logic [31:0]      redirect_pc;
   logic             flush;
   logic             link_we;
   logic [4:0]       link_rd;
   logic [31:0]      link_data;
   logic [CNT_W-1:0] taken_cnt;

   modport master (
      output stall, valid_in, jump_branch, pc_plus4, rs_data, rt_data, offset, target,
      input  redirect, redirect_pc, flush, link_we, link_rd, link_data, taken_cnt
   );

   modport slave (
      input  stall, valid_in, jump_branch, pc_plus4, rs_data, rt_data, offset, target,
      output redirect, redirect_pc, flush, link_we, link_rd, link_data, taken_cnt
   );
endinterface

// File: rtl/jump_branch_resolve.sv
// EX-stage jump/branch resolver. Decodes the 3-bit JumpBranch code, decides
// taken/not-taken, and issues a registered PC redirect, a multi-cycle IF/ID
// flush and the $31 link write for JAL (no delay slot, link = pc_plus4).
// Optional feature: define JB_TAKEN_CNT_EN to build the taken-redirect
// counter; otherwise taken_cnt is tied to zero.
module jump_branch_resolve #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input logic                  clk,
   input logic                  rst,
   jump_branch_resolve_if.slave bus
);

   localparam logic [2:0] JB_BEQ = 3'd1;
   localparam logic [2:0] JB_BNE = 3'd2;
   localparam logic [2:0] JB_JR  = 3'd3;
   localparam logic [2:0] JB_J   = 3'd4;
   localparam logic [2:0] JB_JAL = 3'd7;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   typedef enum logic {
      IDLE,
      FLUSH
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  flush_cnt_q, flush_cnt_d;
   logic        redirect_q, redirect_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        flush_q, flush_d;
   logic        link_we_q, link_we_d;
   logic [31:0] link_data_q, link_data_d;

   logic        taken;
   logic        is_jal;
   logic        accept;
   logic [31:0] branch_tgt;
   logic [31:0] resolved_pc;

   // Decode the code, evaluate the branch condition and form the target
   always_comb begin
      taken       = 1'b0;
      is_jal      = 1'b0;
      branch_tgt  = bus.pc_plus4 + {{14{bus.offset[15]}}, bus.offset, 2'b00};
      resolved_pc = branch_tgt;
      case (bus.jump_branch)
         JB_BEQ: begin
            taken       = (bus.rs_data == bus.rt_data);
            resolved_pc = branch_tgt;
         end
         JB_BNE: begin
            taken       = (bus.rs_data != bus.rt_data);
            resolved_pc = branch_tgt;
         end
         JB_JR: begin
            taken       = 1'b1;
            resolved_pc = bus.rs_data;
         end
         JB_J: begin
            taken       = 1'b1;
            resolved_pc = {bus.pc_plus4[31:28], bus.target, 2'b00};
         end
         JB_JAL: begin
            taken       = 1'b1;
            is_jal      = 1'b1;
            resolved_pc = {bus.pc_plus4[31:28], bus.target, 2'b00};
         end
         default: begin
            taken       = 1'b0;
         end
      endcase
      // The !redirect_q term keeps redirects one cycle apart when the
      // flush is a single cycle and the FSM never leaves IDLE.
      accept = (state_q == IDLE) && bus.valid_in && !bus.stall && taken && !redirect_q;
   end

   // Next-state and next-output logic for the IDLE/FLUSH sequencer
   always_comb begin
      state_d       = state_q;
      flush_cnt_d   = flush_cnt_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      flush_d       = flush_q;
      link_we_d     = 1'b0;
      link_data_d   = link_data_q;
      case (state_q)
         IDLE: begin
            flush_d = 1'b0;
            if (accept) begin
               redirect_d    = 1'b1;
               redirect_pc_d = resolved_pc;
               flush_d       = 1'b1;
               flush_cnt_d   = FLUSH_LOAD;
               state_d       = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
               if (is_jal) begin
                  link_we_d   = 1'b1;
                  link_data_d = bus.pc_plus4;
               end
            end
         end
         FLUSH: begin
            flush_d = 1'b1;
            if (!bus.stall) begin
               if (flush_cnt_q == 4'd0) begin
                  state_d = IDLE;
                  flush_d = 1'b0;
               end else begin
                  flush_cnt_d = flush_cnt_q - 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            flush_d = 1'b0;
         end
      endcase
   end

   // Sequencer state and registered outputs; reset aborts any flush
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         flush_cnt_q   <= 4'd0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= 32'd0;
         flush_q       <= 1'b0;
         link_we_q     <= 1'b0;
         link_data_q   <= 32'd0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         flush_q       <= flush_d;
         link_we_q     <= link_we_d;
         link_data_q   <= link_data_d;
      end
   end

`ifdef JB_TAKEN_CNT_EN
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

   // Count accepted redirects, wrapping naturally at the counter width
   always_comb begin
      taken_cnt_d = taken_cnt_q;
      if (accept) begin
         taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end
   end

   // Taken-redirect counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         taken_cnt_q <= '0;
      end else begin
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign bus.taken_cnt = taken_cnt_q;
`else
   assign bus.taken_cnt = '0;
`endif

   assign bus.redirect    = redirect_q;
   assign bus.redirect_pc = redirect_pc_q;
   assign bus.flush       = flush_q;
   assign bus.link_we     = link_we_q;
   assign bus.link_rd     = 5'd31;
   assign bus.link_data   = link_data_q;

endmodule

// File: tb/tb_jump_branch_resolve.sv
// Directed self-checking bench for jump_branch_resolve. Inputs change and
// outputs are sampled on the falling edge; the DUT samples on the rising edge.
module tb_jump_branch_resolve;

   localparam int CNT_W = 32;

   localparam logic [2:0] C_OTHERS = 3'd0;
   localparam logic [2:0] C_BEQ    = 3'd1;
   localparam logic [2:0] C_BNE    = 3'd2;
   localparam logic [2:0] C_JR     = 3'd3;
   localparam logic [2:0] C_J      = 3'd4;
   localparam logic [2:0] C_JAL    = 3'd7;

   logic clk;
   logic rst;
   int   testsRun;
   int   testsFailed;

   jump_branch_resolve_if #(.CNT_W(CNT_W)) bus ();

   jump_branch_resolve #(
      .FLUSH_CYCLES(2),
      .CNT_W       (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one operand vector onto the ID/EX side of the bus
   task automatic applyStimulus(input logic v, input logic [2:0] code,
                                input logic [31:0] pc, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [15:0] off,
                                input logic [25:0] tgt);
      bus.valid_in    = v;
      bus.jump_branch = code;
      bus.pc_plus4    = pc;
      bus.rs_data     = rs;
      bus.rt_data     = rt;
      bus.offset      = off;
      bus.target      = tgt;
   endtask

   // Count one comparison and report it if it disagrees
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance across one rising edge and land on the next falling edge
   task automatic stepCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, C_OTHERS, 32'd0, 32'd0, 32'd0, 16'd0, 26'd0);
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst         = 1'b1;
      bus.stall   = 1'b0;
      idleInputs();
      @(negedge clk);
      stepCycle();
      checkOutput("reset_redirect", 32'(bus.redirect), 32'd0);
      checkOutput("reset_flush", 32'(bus.flush), 32'd0);
      checkOutput("reset_link_we", 32'(bus.link_we), 32'd0);
      checkOutput("reset_redirect_pc", bus.redirect_pc, 32'd0);
      checkOutput("reset_link_data", bus.link_data, 32'd0);
      checkOutput("reset_taken_cnt", bus.taken_cnt, 32'd0);
      checkOutput("link_rd", 32'(bus.link_rd), 32'd31);
      rst = 1'b0;

      // BEQ taken with negative offset: 0x100 + (-4) = 0xFC, flush 2 cycles
      applyStimulus(1'b1, C_BEQ, 32'h100, 32'd5, 32'd5, 16'hFFFF, 26'd0);
      stepCycle();
      idleInputs();
      checkOutput("beq_redirect", 32'(bus.redirect), 32'd1);
      checkOutput("beq_redirect_pc", bus.redirect_pc, 32'h0000_00FC);
      checkOutput("beq_flush_c1", 32'(bus.flush), 32'd1);
      checkOutput("beq_link_we", 32'(bus.link_we), 32'd0);
      stepCycle();
      checkOutput("beq_redirect_c2", 32'(bus.redirect), 32'd0);
      checkOutput("beq_flush_c2", 32'(bus.flush), 32'd1);
      stepCycle();
      checkOutput("beq_flush_c3", 32'(bus.flush), 32'd0);

      // BNE with equal operands is not taken
      applyStimulus(1'b1, C_BNE, 32'h200, 32'd7, 32'd7, 16'h0010, 26'd0);
      stepCycle();
      checkOutput("bne_nt_redirect", 32'(bus.redirect), 32'd0);
      checkOutput("bne_nt_flush", 32'(bus.flush), 32'd0);
      stepCycle();
      checkOutput("bne_nt_flush2", 32'(bus.flush), 32'd0);

      // JAL: link write for exactly one cycle; JAL held valid during FLUSH is ignored
      applyStimulus(1'b1, C_JAL, 32'h0040_0010, 32'd0, 32'd0, 16'd0, 26'h000_0040);
      stepCycle();
      checkOutput("jal_redirect", 32'(bus.redirect), 32'd1);
      checkOutput("jal_redirect_pc", bus.redirect_pc, 32'h0000_0100);
      checkOutput("jal_link_we", 32'(bus.link_we), 32'd1);
      checkOutput("jal_link_rd", 32'(bus.link_rd), 32'd31);
      checkOutput("jal_link_data", bus.link_data, 32'h0040_0010);
      checkOutput("jal_flush_c1", 32'(bus.flush), 32'd1);
      stepCycle();
      checkOutput("jal_redirect_c2", 32'(bus.redirect), 32'd0);
      checkOutput("jal_link_we_c2", 32'(bus.link_we), 32'd0);
      checkOutput("jal_flush_c2", 32'(bus.flush), 32'd1);
      stepCycle();
      idleInputs();
      checkOutput("jal_flush_c3", 32'(bus.flush), 32'd0);
      checkOutput("jal_redirect_c3", 32'(bus.redirect), 32'd0);
      stepCycle();

      // J enters FLUSH; a JR in the wrong path is ignored; 3 stalls stretch flush to 5
      applyStimulus(1'b1, C_J, 32'h0000_0000, 32'd0, 32'd0, 16'd0, 26'h10);
      stepCycle();
      checkOutput("j_redirect_pc", bus.redirect_pc, 32'h0000_0040);
      checkOutput("stall_flush_c1", 32'(bus.flush), 32'd1);
      applyStimulus(1'b1, C_JR, 32'h0000_0500, 32'h1234, 32'd0, 16'd0, 26'd0);
      stepCycle();
      checkOutput("stall_flush_c2", 32'(bus.flush), 32'd1);
      checkOutput("stall_jr_ignored", 32'(bus.redirect), 32'd0);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput($sformatf("stall_flush_c%0d", i + 3), 32'(bus.flush), 32'd1);
         checkOutput($sformatf("stall_redirect_c%0d", i + 3), 32'(bus.redirect), 32'd0);
      end
      bus.stall = 1'b0;
      stepCycle();
      idleInputs();
      checkOutput("stall_flush_c6", 32'(bus.flush), 32'd0);
      checkOutput("stall_redirect_pc_held", bus.redirect_pc, 32'h0000_0040);

      // Reset in the first FLUSH cycle aborts the flush; a later J is accepted
      applyStimulus(1'b1, C_J, 32'h0000_0000, 32'd0, 32'd0, 16'd0, 26'h20);
      stepCycle();
      idleInputs();
      checkOutput("rst_pre_flush", 32'(bus.flush), 32'd1);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("rst_flush", 32'(bus.flush), 32'd0);
      checkOutput("rst_redirect_pc", bus.redirect_pc, 32'd0);
      checkOutput("rst_taken_cnt", bus.taken_cnt, 32'd0);
      applyStimulus(1'b1, C_J, 32'h1000_0004, 32'd0, 32'd0, 16'd0, 26'h20);
      stepCycle();
      idleInputs();
      checkOutput("post_rst_redirect", 32'(bus.redirect), 32'd1);
      checkOutput("post_rst_redirect_pc", bus.redirect_pc, 32'h1000_0080);
      stepCycle();
      stepCycle();
      checkOutput("post_rst_flush_done", 32'(bus.flush), 32'd0);

      // Clear the counter, then reserved codes must do nothing
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      applyStimulus(1'b1, 3'd5, 32'h300, 32'h44, 32'd0, 16'h0008, 26'h3FF);
      stepCycle();
      checkOutput("code5_redirect", 32'(bus.redirect), 32'd0);
      checkOutput("code5_flush", 32'(bus.flush), 32'd0);
      applyStimulus(1'b1, 3'd6, 32'h300, 32'h44, 32'd0, 16'h0008, 26'h3FF);
      stepCycle();
      checkOutput("code6_redirect", 32'(bus.redirect), 32'd0);
      checkOutput("code6_flush", 32'(bus.flush), 32'd0);

      // Stalled BEQ-taken is not sampled
      applyStimulus(1'b1, C_BEQ, 32'h300, 32'd9, 32'd9, 16'h0001, 26'd0);
      bus.stall = 1'b1;
      stepCycle();
      bus.stall = 1'b0;
      idleInputs();
      checkOutput("stalled_beq_redirect", 32'(bus.redirect), 32'd0);

      // Three taken transfers: BNE taken, JR, BEQ taken
      applyStimulus(1'b1, C_BNE, 32'h200, 32'd1, 32'd2, 16'h0004, 26'd0);
      stepCycle();
      idleInputs();
      checkOutput("bne_t_redirect_pc", bus.redirect_pc, 32'h0000_0210);
      stepCycle();
      stepCycle();
      applyStimulus(1'b1, C_JR, 32'h0000_0800, 32'h1234, 32'd0, 16'd0, 26'd0);
      stepCycle();
      idleInputs();
      checkOutput("jr_redirect_pc", bus.redirect_pc, 32'h0000_1234);
      checkOutput("jr_link_we", 32'(bus.link_we), 32'd0);
      stepCycle();
      stepCycle();
      applyStimulus(1'b1, C_BEQ, 32'hFFFF_FFF0, 32'd3, 32'd3, 16'h0008, 26'd0);
      stepCycle();
      idleInputs();
      checkOutput("beq_wrap_redirect_pc", bus.redirect_pc, 32'h0000_0010);
      stepCycle();
      stepCycle();
`ifdef JB_TAKEN_CNT_EN
      checkOutput("taken_cnt", bus.taken_cnt, 32'd3);
`else
      checkOutput("taken_cnt", bus.taken_cnt, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Hard time limit so the bench always ends
   initial begin
      #100000;
      $display("[TB] FAIL timeout: got no finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
